// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and control-field encodings for the multi-cycle CPU
// Used by the control FSM, its output decoder, Imm_Gen and the datapath muxes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_WB_ALU,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_LUI  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_OP_ADD    = 3'b000;
  localparam logic [2:0] ALU_OP_SUB    = 3'b001;
  localparam logic [2:0] ALU_OP_FUNCT  = 3'b010;
  localparam logic [2:0] ALU_OP_PASS_B = 3'b011;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_IMM    = 2'b10;

  localparam logic [1:0] IMM_SEXT6  = 2'b00;
  localparam logic [1:0] IMM_ZEXT8  = 2'b01;
  localparam logic [1:0] IMM_SEXT8  = 2'b10;
  localparam logic [1:0] IMM_ZEXT12 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] imm_sel;
    logic       halted;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_LUI, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// rtl/ctrl_out_dec.sv - combinational state+opcode to control-word decoder
// Ports: state (FSM state), opcode (Instr[15:12]), mem_ready (gates IR/PC load in FETCH),
//        ctrl (full datapath control word, including the halted indication).
import ctrl_pkg::*;

module ctrl_out_dec (
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_ONE;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        // PC and IR load together so the PC never advances past an unloaded instruction.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_sel   = IMM_SEXT8;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        if (opcode == OP_LUI) begin
          ctrl.imm_sel = IMM_ZEXT8;
          ctrl.alu_op  = ALU_OP_PASS_B;
        end else begin
          ctrl.imm_sel = IMM_SEXT6;
          ctrl.alu_op  = ALU_OP_ADD;
        end
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_sel   = IMM_SEXT6;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_IMM;
        ctrl.imm_sel  = IMM_ZEXT12;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - main control FSM of the multi-cycle 16-bit RISC CPU
// Inputs: Clk, Rst_n (async active-low), Instr (IR), Zero (ALU flag), Mem_Ready.
// Outputs: PC/IR/regfile/memory enables and mux selects, Imm_Sel, Halted,
//          sticky Illegal, and the retired-instruction counter Instr_Count.
import ctrl_pkg::*;

module multi_cycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [15:0]      Instr,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             PC_Write_Cond,
  output logic             IorD,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             IR_Write,
  output logic             Reg_Write,
  output logic             Mem_to_Reg,
  output logic             ALU_Src_A,
  output logic [1:0]       ALU_Src_B,
  output logic [2:0]       ALU_Op,
  output logic [1:0]       PC_Src,
  output logic [1:0]       Imm_Sel,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t           state, next_state;
  logic [3:0]       opcode;
  logic             retire;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  ctrl_word_t       ctrl;

  // Zero is ANDed with PC_Write_Cond in the datapath; operand fields go to Imm_Gen/ALU.
  logic unused_inputs;
  assign unused_inputs = Zero ^ (^Instr[11:0]);

  assign opcode = Instr[15:12];

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  if (Mem_Ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:           next_state = S_EXEC_R;
          OP_ADDI, OP_LUI: next_state = S_EXEC_I;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ:         next_state = S_BRANCH;
          OP_JMP:         next_state = S_JUMP;
          default:        next_state = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (Mem_Ready) next_state = S_MEM_WB;
      S_MEM_WR:   if (Mem_Ready) next_state = S_FETCH;
      S_WB_ALU, S_MEM_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_INIT;
    endcase
  end

  // An instruction retires on its final state's exit; INIT->FETCH is not a retirement.
  assign retire = (next_state == S_FETCH) &&
                  (state inside {S_WB_ALU, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_INIT;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) count_q <= count_q + CNT_W'(1);
      if ((state == S_DECODE) && !is_legal_op(opcode)) illegal_q <= 1'b1;
    end
  end

  ctrl_out_dec u_dec (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (Mem_Ready),
    .ctrl      (ctrl)
  );

  assign PC_Write      = ctrl.pc_write;
  assign PC_Write_Cond = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign Mem_Read      = ctrl.mem_read;
  assign Mem_Write     = ctrl.mem_write;
  assign IR_Write      = ctrl.ir_write;
  assign Reg_Write     = ctrl.reg_write;
  assign Mem_to_Reg    = ctrl.mem_to_reg;
  assign ALU_Src_A     = ctrl.alu_src_a;
  assign ALU_Src_B     = ctrl.alu_src_b;
  assign ALU_Op        = ctrl.alu_op;
  assign PC_Src        = ctrl.pc_src;
  assign Imm_Sel       = ctrl.imm_sel;
  assign Halted        = ctrl.halted;
  assign Illegal       = illegal_q;
  assign Instr_Count   = count_q;

endmodule
